// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back cache: sequences CPU hits, victim writeback
// and line allocation, and keeps saturating hit/miss/writeback counters.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 ishit_w1,
  input  logic                 ishit_w2,
  input  logic                 isdirty_w1,
  input  logic                 isdirty_w2,
  input  logic                 lru_out,
  output logic                 load_dirty_w1,
  output logic                 load_valid_w1,
  output logic                 load_tag_w1,
  output logic                 load_datastore_w1,
  output logic                 load_dirty_w2,
  output logic                 load_valid_w2,
  output logic                 load_tag_w2,
  output logic                 load_datastore_w2,
  output logic                 load_lru,
  output logic                 dirty_datain,
  output logic                 datastore_in_mux_sel,
  output logic [1:0]           pmem_address_mux_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_WRITEBACK = 2'b01,
    S_ALLOCATE  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 w_req;
  logic                 w_hit;
  logic                 w_hit_way;
  logic                 w_victim_dirty;
  logic                 w_miss_evt;
  logic                 w_wb_evt;
  logic                 w_mem_resp;
  logic                 w_pmem_read;
  logic                 w_pmem_write;
  logic [1:0]           w_ld_dirty;
  logic [1:0]           w_ld_valid;
  logic [1:0]           w_ld_tag;
  logic [1:0]           w_ld_data;
  logic                 w_load_lru;
  logic                 w_dirty_datain;
  logic                 w_ds_sel;
  logic [1:0]           w_addr_sel;
  logic [CNT_WIDTH-1:0] r_hit_cnt;
  logic [CNT_WIDTH-1:0] r_miss_cnt;
  logic [CNT_WIDTH-1:0] r_wb_cnt;

  // Way index 0 = way 1, 1 = way 2; way 1 wins when both hit.
  assign w_req          = mem_read | mem_write;
  assign w_hit          = ishit_w1 | ishit_w2;
  assign w_hit_way      = ~ishit_w1;
  assign w_victim_dirty = lru_out ? isdirty_w2 : isdirty_w1;
  assign w_miss_evt     = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_wb_evt       = w_miss_evt && w_victim_dirty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_miss_evt) w_next = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
      S_WRITEBACK: if (pmem_resp) w_next = S_ALLOCATE;
      S_ALLOCATE:  if (pmem_resp) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_resp     = 1'b0;
    w_pmem_read    = 1'b0;
    w_pmem_write   = 1'b0;
    w_ld_dirty     = 2'b00;
    w_ld_valid     = 2'b00;
    w_ld_tag       = 2'b00;
    w_ld_data      = 2'b00;
    w_load_lru     = 1'b0;
    w_dirty_datain = 1'b0;
    w_ds_sel       = 1'b0;
    w_addr_sel     = 2'b10;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_hit) begin
          w_mem_resp = 1'b1;
          w_load_lru = (w_hit_way == lru_out);
          if (mem_write) begin
            w_ld_data[w_hit_way]  = 1'b1;
            w_ld_dirty[w_hit_way] = 1'b1;
            w_dirty_datain        = 1'b1;
          end
        end
      end
      S_WRITEBACK: begin
        w_pmem_write = 1'b1;
        w_addr_sel   = {1'b0, lru_out};
      end
      S_ALLOCATE: begin
        w_pmem_read = 1'b1;
        if (pmem_resp) begin
          w_ld_data[lru_out]  = 1'b1;
          w_ld_tag[lru_out]   = 1'b1;
          w_ld_valid[lru_out] = 1'b1;
          w_ld_dirty[lru_out] = 1'b1;
          w_ds_sel            = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Reset gate keeps every strobe low while rst_n is asserted, whatever the inputs do.
  assign mem_resp             = rst_n & w_mem_resp;
  assign pmem_read            = rst_n & w_pmem_read;
  assign pmem_write           = rst_n & w_pmem_write;
  assign load_dirty_w1        = rst_n & w_ld_dirty[0];
  assign load_valid_w1        = rst_n & w_ld_valid[0];
  assign load_tag_w1          = rst_n & w_ld_tag[0];
  assign load_datastore_w1    = rst_n & w_ld_data[0];
  assign load_dirty_w2        = rst_n & w_ld_dirty[1];
  assign load_valid_w2        = rst_n & w_ld_valid[1];
  assign load_tag_w2          = rst_n & w_ld_tag[1];
  assign load_datastore_w2    = rst_n & w_ld_data[1];
  assign load_lru             = rst_n & w_load_lru;
  assign dirty_datain         = rst_n & w_dirty_datain;
  assign datastore_in_mux_sel = rst_n & w_ds_sel;
  assign pmem_address_mux_sel = rst_n ? w_addr_sel : 2'b00;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_mem_resp && (r_hit_cnt != '1))  r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
      if (w_miss_evt && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      if (w_wb_evt && (r_wb_cnt != '1))     r_wb_cnt   <= r_wb_cnt + CNT_WIDTH'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, clean/dirty misses, async reset and
// counter saturation (a second 3-bit-counter instance shares the stimulus).
module tb_cache_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, pmem_resp;
  logic        ishit_w1, ishit_w2, isdirty_w1, isdirty_w2, lru_out;
  logic        mem_resp, pmem_read, pmem_write;
  logic        load_dirty_w1, load_valid_w1, load_tag_w1, load_datastore_w1;
  logic        load_dirty_w2, load_valid_w2, load_tag_w2, load_datastore_w2;
  logic        load_lru, dirty_datain, datastore_in_mux_sel;
  logic [1:0]  pmem_address_mux_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  logic        s_mem_resp, s_pmem_read, s_pmem_write;
  logic        s_ld_d1, s_ld_v1, s_ld_t1, s_ld_ds1, s_ld_d2, s_ld_v2, s_ld_t2, s_ld_ds2;
  logic        s_load_lru, s_dirty_datain, s_ds_sel;
  logic [1:0]  s_addr_sel;
  logic [2:0]  s_hit_count, s_miss_count, s_wb_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_control u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
    .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2), .lru_out(lru_out),
    .load_dirty_w1(load_dirty_w1), .load_valid_w1(load_valid_w1),
    .load_tag_w1(load_tag_w1), .load_datastore_w1(load_datastore_w1),
    .load_dirty_w2(load_dirty_w2), .load_valid_w2(load_valid_w2),
    .load_tag_w2(load_tag_w2), .load_datastore_w2(load_datastore_w2),
    .load_lru(load_lru), .dirty_datain(dirty_datain),
    .datastore_in_mux_sel(datastore_in_mux_sel),
    .pmem_address_mux_sel(pmem_address_mux_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control #(.CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_resp(pmem_resp), .ishit_w1(ishit_w1), .ishit_w2(ishit_w2),
    .isdirty_w1(isdirty_w1), .isdirty_w2(isdirty_w2), .lru_out(lru_out),
    .load_dirty_w1(s_ld_d1), .load_valid_w1(s_ld_v1),
    .load_tag_w1(s_ld_t1), .load_datastore_w1(s_ld_ds1),
    .load_dirty_w2(s_ld_d2), .load_valid_w2(s_ld_v2),
    .load_tag_w2(s_ld_t2), .load_datastore_w2(s_ld_ds2),
    .load_lru(s_load_lru), .dirty_datain(s_dirty_datain),
    .datastore_in_mux_sel(s_ds_sel),
    .pmem_address_mux_sel(s_addr_sel),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    ishit_w1 = 0; ishit_w2 = 0; isdirty_w1 = 0; isdirty_w2 = 0; lru_out = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);

    // Reset gate: request + hit while in reset must not raise anything
    mem_read = 1; ishit_w1 = 1;
    #1;
    check("rst_mem_resp", 32'(mem_resp), 0);
    check("rst_load_lru", 32'(load_lru), 0);
    check("rst_pmem", 32'({pmem_read, pmem_write}), 0);
    check("rst_counters", 32'({hit_count, miss_count} | 32'(wb_count)), 0);

    // Release reset with read hit on way 1, lru_out = 0
    @(negedge clk);
    rst_n = 1;
    #1;
    check("h1_mem_resp", 32'(mem_resp), 1);
    check("h1_load_lru", 32'(load_lru), 1);
    check("h1_no_ds", 32'({load_datastore_w1, load_datastore_w2}), 0);
    @(negedge clk);
    check("h1_hit_count", 32'(hit_count), 1);

    // Read hit on way 2, lru_out = 0
    idle_inputs(); mem_read = 1; ishit_w2 = 1;
    #1;
    check("h2_mem_resp", 32'(mem_resp), 1);
    check("h2_load_lru", 32'(load_lru), 0);
    check("h2_no_ds", 32'({load_datastore_w1, load_datastore_w2}), 0);
    @(negedge clk);

    // Write hit on way 2
    idle_inputs(); mem_write = 1; ishit_w2 = 1;
    #1;
    check("wh_mem_resp", 32'(mem_resp), 1);
    check("wh_strobes", 32'({load_datastore_w2, load_dirty_w2, dirty_datain, datastore_in_mux_sel}), 32'b1110);
    check("wh_w1_quiet", 32'({load_datastore_w1, load_dirty_w1}), 0);
    @(negedge clk);

    // Both ways hit (read+write asserted => write): way 1 wins
    idle_inputs(); mem_read = 1; mem_write = 1; ishit_w1 = 1; ishit_w2 = 1;
    #1;
    check("bh_ds", 32'({load_datastore_w1, load_datastore_w2}), 32'b10);
    check("bh_load_lru", 32'(load_lru), 1);
    @(negedge clk);
    check("bh_hit_count", 32'(hit_count), 4);

    // pmem_resp while IDLE is ignored
    idle_inputs(); pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0;
    #1;
    check("idle_resp_ignored", 32'({pmem_read, pmem_write}), 0);
    @(negedge clk);

    // Clean miss, lru_out = 1 (way-1 dirty bit must be irrelevant), pmem latency 3
    idle_inputs(); mem_read = 1; lru_out = 1; isdirty_w1 = 1;
    #1;
    check("cm_req_resp", 32'({mem_resp, pmem_read, pmem_write}), 0);
    @(negedge clk);
    check("cm_miss_count", 32'(miss_count), 1);
    check("cm_wb_count", 32'(wb_count), 0);
    for (int i = 0; i < 3; i++) begin
      pmem_resp = (i == 2);
      #1;
      check("cm_pmem_read", 32'({pmem_read, pmem_write}), 32'b10);
      check("cm_sel", 32'(pmem_address_mux_sel), 32'b10);
      if (i < 2) check("cm_wait_quiet", 32'({load_datastore_w2, mem_resp}), 0);
      else begin
        check("cm_fill_w2", 32'({load_datastore_w2, load_tag_w2, load_valid_w2, load_dirty_w2}), 32'hF);
        check("cm_fill_ctl", 32'({dirty_datain, datastore_in_mux_sel}), 32'b01);
        check("cm_fill_w1_quiet", 32'({load_datastore_w1, load_tag_w1, load_valid_w1, load_dirty_w1}), 0);
      end
      @(negedge clk);
    end
    pmem_resp = 0; ishit_w2 = 1;
    #1;
    check("cm_rehit_resp", 32'(mem_resp), 1);
    check("cm_rehit_lru", 32'(load_lru), 1);
    @(negedge clk);
    check("cm_counts", 32'({hit_count, miss_count}), {16'd5, 16'd1});

    // Dirty miss, lru_out = 0, way 1 dirty; writeback 2 cycles, read 2 cycles
    idle_inputs(); mem_write = 1; isdirty_w1 = 1;
    #1;
    check("dm_req_resp", 32'({mem_resp, pmem_read, pmem_write}), 0);
    @(negedge clk);
    check("dm_wb_count", 32'(wb_count), 1);
    check("dm_miss_count", 32'(miss_count), 2);
    for (int i = 0; i < 2; i++) begin
      pmem_resp = (i == 1);
      #1;
      check("dm_wb_phase", 32'({pmem_read, pmem_write}), 32'b01);
      check("dm_wb_sel", 32'(pmem_address_mux_sel), 32'b00);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      pmem_resp = (i == 1);
      #1;
      check("dm_rd_phase", 32'({pmem_read, pmem_write}), 32'b10);
      check("dm_rd_sel", 32'(pmem_address_mux_sel), 32'b10);
      if (i == 1)
        check("dm_fill_w1", 32'({load_datastore_w1, load_tag_w1, load_valid_w1, load_dirty_w1, dirty_datain}), 32'b11110);
      @(negedge clk);
    end
    pmem_resp = 0; ishit_w1 = 1;
    #1;
    check("dm_rehit", 32'({mem_resp, load_datastore_w1, load_dirty_w1, dirty_datain, load_lru}), 32'b11111);
    @(negedge clk);
    check("dm_hit_count", 32'(hit_count), 6);

    // Async reset mid-ALLOCATE
    idle_inputs(); mem_read = 1;
    @(negedge clk);
    #1;
    check("ar_in_alloc", 32'(pmem_read), 1);
    #1 rst_n = 0;
    #1;
    check("ar_pmem_drop", 32'({pmem_read, pmem_write}), 0);
    check("ar_counters", 32'({hit_count, miss_count}), 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    #1;
    check("ar_idle_after", 32'({pmem_read, pmem_write, mem_resp}), 0);
    @(negedge clk);

    // Nine clean misses, each dropped during ALLOCATE with an immediate resp
    for (int i = 0; i < 9; i++) begin
      idle_inputs(); mem_read = 1;
      @(negedge clk);
      mem_read = 0; pmem_resp = 1;
      #1;
      if (i == 8) check("sat_dropped_no_resp", 32'({mem_resp, pmem_read}), 32'b01);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("sat_full_miss", 32'(miss_count), 9);
    check("sat_small_miss", 32'(s_miss_count), 7);
    check("sat_small_hit", 32'(s_hit_count), 0);
    check("sat_back_idle", 32'({pmem_read, pmem_write}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
